// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: fetch FSM states and
// the fixed encodings the fetch stage relies on.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_timer.sv
// Loadable up-counter with clear; o_tc flags the cycle in which an enabled
// count reaches LIMIT, i.e. the LIMIT-th enabled cycle since the last load.
module fetch_timer #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_en,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = i_en && (r_count == TC_VALUE);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches one word per load_ir over
// a req/ack handshake, supports branch redirect, restart and a fetch timeout.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_ir,
  input  logic              load_pc,
  input  logic              clear_pc,
  input  logic [31:0]       pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [31:0]       pc,
  output logic              busy,
  output logic              fetch_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  fetch_state_t r_state, w_nextState;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_irValid;
  logic        r_fetchErr;
  logic        r_pendValid;
  logic [31:0] r_pendPc;

  logic [31:0] w_target;
  logic        w_inReq;
  logic        w_tc;

  assign w_target = pc_in & ~32'h3;
  assign w_inReq  = (r_state == REQ);

  fetch_timer #(
    .WIDTH(TW),
    .LIMIT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (clear_pc),
    .i_load   ((r_state == IDLE) && load_ir),
    .i_loadVal('0),
    .i_en     (w_inReq && !imem_ack),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // An ack in the timeout cycle completes the fetch; clear_pc overrides all.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (load_ir) w_nextState = REQ;
      REQ: begin
        if (imem_ack) begin
          w_nextState = IDLE;
        end else if (w_tc) begin
          w_nextState = ERR;
        end
      end
      ERR:     w_nextState = ERR;
      default: w_nextState = IDLE;
    endcase
    if (clear_pc) w_nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= NOP;
      r_irValid   <= 1'b0;
      r_fetchErr  <= 1'b0;
      r_pendValid <= 1'b0;
      r_pendPc    <= '0;
    end else begin
      r_irValid <= 1'b0;
      if (clear_pc) begin
        r_pc        <= RESET_PC;
        r_ir        <= NOP;
        r_fetchErr  <= 1'b0;
        r_pendValid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (load_pc) r_pc <= w_target;
          REQ: begin
            if (imem_ack) begin
              r_ir        <= imem_rdata;
              r_irValid   <= 1'b1;
              r_pendValid <= 1'b0;
              // A redirect arriving with the ack is the newest one and wins.
              if (load_pc) begin
                r_pc <= w_target;
              end else if (r_pendValid) begin
                r_pc <= r_pendPc;
              end else begin
                r_pc <= r_pc + PC_INC;
              end
            end else begin
              if (load_pc) begin
                r_pendValid <= 1'b1;
                r_pendPc    <= w_target;
              end
              if (w_tc) r_fetchErr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_req  = w_inReq;
  assign busy      = w_inReq;
  assign imem_addr = r_pc[ADDR_W+1:2];
  assign ir        = r_ir;
  assign ir_valid  = r_irValid;
  assign pc        = r_pc;
  assign fetch_err = r_fetchErr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_fetch_unit;

  localparam int          ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_ir = 1'b0, load_pc = 1'b0, clear_pc = 1'b0, imem_ack = 1'b0;
  logic [31:0] pc_in = '0, imem_rdata = '0;
  logic imem_req, ir_valid, busy, fetch_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] ir, pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_ir   (load_ir),
    .load_pc   (load_pc),
    .clear_pc  (clear_pc),
    .pc_in     (pc_in),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ack  (imem_ack),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0; load_ir = 0; load_pc = 0; clear_pc = 0; imem_ack = 0;
    pc_in = '0; imem_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic doFetch(input int ackDelay, input logic [31:0] data,
                         output int reqCycles, output int busyCycles,
                         output int validPulses, output logic [ADDR_W-1:0] firstAddr);
    reqCycles = 0; busyCycles = 0; validPulses = 0;
    @(negedge clk); load_ir = 1'b1;
    @(negedge clk); load_ir = 1'b0;
    firstAddr = imem_addr;
    for (int i = 0; i < ackDelay; i++) begin
      if (imem_req) reqCycles++;
      if (busy) busyCycles++;
      @(negedge clk);
    end
    if (imem_req) reqCycles++;
    if (busy) busyCycles++;
    imem_ack = 1'b1; imem_rdata = data;
    @(negedge clk); imem_ack = 1'b0;
    if (ir_valid) validPulses++;
    repeat (2) begin
      @(negedge clk);
      if (ir_valid) validPulses++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== RESET_PC) begin failures++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    checks++;
    if (ir !== 32'h0) begin failures++; $display("[TB] FAIL reset_ir: got %h expected 0", ir); end
    checks++;
    if ({imem_req, busy, ir_valid, fetch_err} !== 4'b0000)
      begin failures++; $display("[TB] FAIL reset_flags: got %b expected 0000", {imem_req, busy, ir_valid, fetch_err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    int rc, bc, vp; logic [ADDR_W-1:0] a0;
    resetDut();
    doFetch(0, 32'h0200_0005, rc, bc, vp, a0);
    checks++;
    if (ir !== 32'h0200_0005) begin failures++; $display("[TB] FAIL basic_ir: got %h expected 02000005", ir); end
    checks++;
    if (vp !== 1) begin failures++; $display("[TB] FAIL basic_valid_pulses: got %0d expected 1", vp); end
    checks++;
    if (pc !== 32'd4) begin failures++; $display("[TB] FAIL basic_pc: got %h expected 4", pc); end
    checks++;
    if (a0 !== '0) begin failures++; $display("[TB] FAIL basic_addr: got %h expected 0", a0); end
    checks++;
    if (rc !== 1) begin failures++; $display("[TB] FAIL basic_req_cycles: got %0d expected 1", rc); end
  endtask

  task automatic test_back_to_back();
    int rc, bc, vp; logic [ADDR_W-1:0] a0;
    logic [31:0] d;
    resetDut();
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      doFetch(2 + k, d, rc, bc, vp, a0);
      checks++;
      if (rc !== 3 + k) begin failures++; $display("[TB] FAIL b2b_req_cycles[%0d]: got %0d expected %0d", k, rc, 3 + k); end
      checks++;
      if (bc !== rc) begin failures++; $display("[TB] FAIL b2b_busy_cycles[%0d]: got %0d expected %0d", k, bc, rc); end
      checks++;
      if (a0 !== ADDR_W'(k)) begin failures++; $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", k, a0, k); end
      checks++;
      if (ir !== d || vp !== 1) begin failures++; $display("[TB] FAIL b2b_ir[%0d]: got %h/%0d expected %h/1", k, ir, vp, d); end
    end
    checks++;
    if (pc !== 32'd8) begin failures++; $display("[TB] FAIL b2b_pc: got %h expected 8", pc); end
  endtask

  task automatic test_ack_at_limit();
    int rc, bc, vp; logic [ADDR_W-1:0] a0;
    logic [31:0] d;
    resetDut();
    d = $urandom;
    doFetch(TIMEOUT - 1, d, rc, bc, vp, a0);
    checks++;
    if (rc !== TIMEOUT) begin failures++; $display("[TB] FAIL limit_req_cycles: got %0d expected %0d", rc, TIMEOUT); end
    checks++;
    if (fetch_err !== 1'b0 || ir !== d || pc !== 32'd4)
      begin failures++; $display("[TB] FAIL limit_ack_wins: got err=%b ir=%h pc=%h expected err=0 ir=%h pc=4", fetch_err, ir, pc, d); end
  endtask

  task automatic test_redirect_idle();
    int rc, bc, vp; logic [ADDR_W-1:0] a0;
    resetDut();
    @(negedge clk); load_pc = 1'b1; pc_in = 32'h0000_0103;
    @(negedge clk); load_pc = 1'b0;
    checks++;
    if (pc !== 32'h100) begin failures++; $display("[TB] FAIL redir_idle_pc: got %h expected 100", pc); end
    doFetch(1, 32'hCAFE_0001, rc, bc, vp, a0);
    checks++;
    if (a0 !== ADDR_W'(10'h40)) begin failures++; $display("[TB] FAIL redir_idle_addr: got %h expected 40", a0); end
    checks++;
    if (pc !== 32'h104) begin failures++; $display("[TB] FAIL redir_idle_next_pc: got %h expected 104", pc); end
  endtask

  task automatic test_redirect_in_req();
    logic [31:0] d;
    resetDut();
    d = $urandom;
    @(negedge clk); load_ir = 1'b1;
    @(negedge clk); load_ir = 1'b0; load_pc = 1'b1; pc_in = 32'h0000_01F0;
    @(negedge clk); pc_in = 32'h0000_0203;
    @(negedge clk); load_pc = 1'b0;
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== '0)
      begin failures++; $display("[TB] FAIL redir_req_hold: got pc=%h req=%b addr=%h expected 0/1/0", pc, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = d;
    @(negedge clk); imem_ack = 1'b0;
    checks++;
    if (ir !== d || ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL redir_req_ir: got %h/%b expected %h/1", ir, ir_valid, d); end
    checks++;
    if (pc !== 32'h200) begin failures++; $display("[TB] FAIL redir_req_pc: got %h expected 200", pc); end
  endtask

  task automatic test_timeout();
    int rc, bc, vp, n; logic [ADDR_W-1:0] a0;
    logic [31:0] d1, d2;
    resetDut();
    d1 = $urandom | 32'h1; d2 = $urandom;
    doFetch(0, d1, rc, bc, vp, a0);
    @(negedge clk); load_ir = 1'b1;
    @(negedge clk); load_ir = 1'b0;
    n = 0;
    while (imem_req && n < 3 * TIMEOUT) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== TIMEOUT) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT); end
    checks++;
    if ({fetch_err, imem_req, busy} !== 3'b100 || ir !== d1)
      begin failures++; $display("[TB] FAIL timeout_state: got err/req/busy=%b ir=%h expected 100 ir=%h", {fetch_err, imem_req, busy}, ir, d1); end
    @(negedge clk); load_ir = 1'b1; load_pc = 1'b1; pc_in = 32'h300;
    @(negedge clk); load_ir = 1'b0; load_pc = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || fetch_err !== 1'b1 || pc !== 32'd4)
      begin failures++; $display("[TB] FAIL err_ignores: got req=%b err=%b pc=%h expected 0/1/4", imem_req, fetch_err, pc); end
    clear_pc = 1'b1;
    @(negedge clk); clear_pc = 1'b0;
    checks++;
    if (pc !== RESET_PC || ir !== 32'h0 || fetch_err !== 1'b0)
      begin failures++; $display("[TB] FAIL clear_from_err: got pc=%h ir=%h err=%b expected %h/0/0", pc, ir, fetch_err, RESET_PC); end
    doFetch(0, d2, rc, bc, vp, a0);
    checks++;
    if (ir !== d2 || pc !== 32'd4) begin failures++; $display("[TB] FAIL fetch_after_clear: got ir=%h pc=%h expected %h/4", ir, pc, d2); end
  endtask

  task automatic test_clear_ack();
    int rc, bc, vp; logic [ADDR_W-1:0] a0;
    resetDut();
    doFetch(0, 32'h1234_5678, rc, bc, vp, a0);
    @(negedge clk); load_ir = 1'b1;
    @(negedge clk); load_ir = 1'b0;
    clear_pc = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); clear_pc = 1'b0; imem_ack = 1'b0;
    checks++;
    if (ir !== 32'h0 || pc !== RESET_PC || ir_valid !== 1'b0 || imem_req !== 1'b0)
      begin failures++; $display("[TB] FAIL clear_ack: got ir=%h pc=%h valid=%b req=%b expected 0/%h/0/0", ir, pc, ir_valid, imem_req, RESET_PC); end
    @(negedge clk);
    checks++;
    if (ir_valid !== 1'b0 || ir !== 32'h0) begin failures++; $display("[TB] FAIL clear_ack_late: got valid=%b ir=%h expected 0/0", ir_valid, ir); end
  endtask

  task automatic test_reset_mid_req();
    int rc, bc, vp; logic [ADDR_W-1:0] a0;
    resetDut();
    doFetch(0, 32'h0BAD_F00D, rc, bc, vp, a0);
    @(negedge clk); load_ir = 1'b1;
    @(negedge clk); load_ir = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== RESET_PC || ir !== 32'h0)
      begin failures++; $display("[TB] FAIL async_reset: got req=%b busy=%b pc=%h ir=%h expected 0/0/%h/0", imem_req, busy, pc, ir, RESET_PC); end
    @(negedge clk); rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    @(negedge clk); imem_ack = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || ir !== 32'h0 || imem_req !== 1'b0 || pc !== RESET_PC)
      begin failures++; $display("[TB] FAIL late_ack_ignored: got valid=%b ir=%h req=%b pc=%h expected 0/0/0/%h", ir_valid, ir, imem_req, pc, RESET_PC); end
  endtask

  // Reference model tracks the fetch as a transaction: idle, outstanding
  // (with a wait count and at most one queued redirect) or failed.
  task automatic test_random();
    bit mBusy, mErr, mValid;
    int mWait, ackPct;
    logic [31:0] mPc, mIr;
    logic [31:0] redirect[$];
    bit li, lp, cp, ack;
    logic [31:0] rd, pin;
    resetDut();
    mBusy = 0; mErr = 0; mValid = 0; mWait = 0; mPc = RESET_PC; mIr = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== mBusy) begin failures++; $display("[TB] FAIL rnd_req@%0d: got %b expected %b", cyc, imem_req, mBusy); end
      checks++;
      if (busy !== mBusy) begin failures++; $display("[TB] FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, mBusy); end
      checks++;
      if (pc !== mPc) begin failures++; $display("[TB] FAIL rnd_pc@%0d: got %h expected %h", cyc, pc, mPc); end
      checks++;
      if (imem_addr !== mPc[ADDR_W+1:2]) begin failures++; $display("[TB] FAIL rnd_addr@%0d: got %h expected %h", cyc, imem_addr, mPc[ADDR_W+1:2]); end
      checks++;
      if (ir !== mIr) begin failures++; $display("[TB] FAIL rnd_ir@%0d: got %h expected %h", cyc, ir, mIr); end
      checks++;
      if (ir_valid !== mValid) begin failures++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", cyc, ir_valid, mValid); end
      checks++;
      if (fetch_err !== mErr) begin failures++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", cyc, fetch_err, mErr); end

      ackPct = ((cyc / 100) % 2 == 1) ? 4 : 40;
      li  = ($urandom_range(99) < 30);
      lp  = ($urandom_range(99) < 15);
      cp  = ($urandom_range(99) < 2);
      ack = ($urandom_range(99) < ackPct);
      rd  = $urandom;
      pin = $urandom;
      load_ir = li; load_pc = lp; clear_pc = cp; imem_ack = ack; imem_rdata = rd; pc_in = pin;

      mValid = 0;
      if (cp) begin
        mPc = RESET_PC; mIr = 32'h0; redirect.delete(); mWait = 0; mErr = 0; mBusy = 0;
      end else if (mErr) begin
        mErr = 1;
      end else if (!mBusy) begin
        if (lp) mPc = {pin[31:2], 2'b00};
        if (li) begin mBusy = 1; mWait = 0; end
      end else if (ack) begin
        mIr = rd; mValid = 1; mBusy = 0;
        if (lp) mPc = {pin[31:2], 2'b00};
        else if (redirect.size() > 0) mPc = redirect[0];
        else mPc = mPc + 32'd4;
        redirect.delete();
      end else begin
        if (lp) begin redirect.delete(); redirect.push_back({pin[31:2], 2'b00}); end
        mWait++;
        if (mWait == TIMEOUT) begin mErr = 1; mBusy = 0; end
      end
    end
    @(negedge clk);
    load_ir = 0; load_pc = 0; clear_pc = 0; imem_ack = 0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_ack_at_limit();
    test_redirect_idle();
    test_redirect_in_req();
    test_timeout();
    test_clear_ack();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
